track_scroll_sequencer: RTL and testbench
=========================================

# track_scroll_sequencer

Frame-synchronous VRAM sequencer for the track display region. On every Nth frame start, it shifts the track rows of VRAM up by one row: word i+ROW_WORDS is copied to word i. It then writes a fill word into the vacated last row. It shares the single Avalon-side VRAM port with the CPU by stalling whenever the Avalon interface is using that port, and it sits beside the VGA text/track interface inside the same Avalon slave.

## Interface
Parameters:
- BASE_ADDR, 0: first VRAM word of the track region
- ROW_WORDS, 20: words per row (80 chars / 4 per word)
- ROWS, 15: rows in the region; BASE_ADDR + ROWS*ROW_WORDS ≤ 512 (elaboration error otherwise)

Ports:
- CLK  in  1  system clock (50 MHz, same domain as VGA controller)
- RESET  in  1  synchronous, active-high
- vs  in  1  VGA vertical sync, active low
- enable  in  1  scrolling enabled
- frames_per_step  in  4  scroll once every frames_per_step+1 frames
- fill_word  in  32  word written into each word of the last row
- avl_busy  in  1  Avalon read or write to VRAM this cycle; sequencer must not strobe
- dma_addr  out  9  VRAM word address
- dma_rden  out  1  read strobe; data on dma_rdata next cycle
- dma_wren  out  1  write strobe, all byte lanes
- dma_wdata  out  32  write data
- dma_rdata  in  32  VRAM read data
- busy  out  1  step in progress
- step_done  out  1  one-cycle pulse at end of a step
- overrun  out  1  sticky; frame tick arrived while busy

## Operation
- Frame tick: vs_q registered each cycle; tick = vs_q & ~vs (falling edge). vs_q resets to 1.
- Frame counter fcnt (4 bit):
  - On a tick while idle and enable=1: if fcnt == frames_per_step, start a step and clear fcnt; else fcnt+1.
  - While enable=0, fcnt is held at 0.
- Copy index idx runs 0 .. (ROWS-1)*ROW_WORDS-1. Source address = BASE_ADDR+idx+ROW_WORDS; destination address = BASE_ADDR+idx. Arithmetic is done at 9 bits and never wraps, per the parameter constraint.
- States:
  - IDLE: wait for a start condition; go to READ with idx=0.
  - READ: if ~avl_busy, assert dma_rden and dma_addr=src, then go to CAPT. Otherwise hold with no strobe.
  - CAPT: latch dma_rdata into hold_q unconditionally, then go to WRITE.
  - WRITE: if ~avl_busy, assert dma_wren, dma_addr=dst, dma_wdata=hold_q. If idx is the last index, go to FILL with idx=0; otherwise idx+1 and go to READ.
  - FILL: if ~avl_busy, write fill_word to BASE_ADDR+(ROWS-1)*ROW_WORDS+idx. After the ROW_WORDS-th write, go to DONE.
  - DONE: step_done=1 for one cycle, then go to IDLE.
- busy = (state != IDLE).
- A tick while busy is dropped, sets overrun, and does not advance fcnt. overrun clears only on RESET.
- Deasserting enable mid-step does not abort; the step completes.
- Changes to frames_per_step take effect at the next tick compare.
- dma_rden and dma_wren are never both high in the same cycle. Neither is ever high while avl_busy=1.
- ROWS=1: the copy phase is skipped; READ goes straight to FILL.

## Timing
- Reset values: state IDLE; all outputs 0; fcnt=0; hold_q=0; vs_q=1.
- Step start: tick seen in cycle t (registered edge) → READ in t+1 → first dma_rden in t+1 if avl_busy=0.
- Read latency is 1 cycle. Unstalled, each copied word takes 3 cycles and each fill word takes 1 cycle.
- Default step: 280*3 + 20 + 1 (DONE) = 861 cycles, well inside vblank (~72k cycles).
- Each cycle of avl_busy during READ, WRITE or FILL adds exactly one cycle.
- RESET mid-step returns to IDLE on the next edge. Partially shifted VRAM contents are left as is.

## Configuration
- SCROLL_FILL_EN defined: the FILL state is present as described and the last row is written with fill_word.
- SCROLL_FILL_EN undefined:
  - FILL is removed; WRITE of the last index goes directly to DONE.
  - The last row keeps its old contents, so it duplicates the row above.
  - fill_word is unused.
  - Step length is 3*(ROWS-1)*ROW_WORDS + 1 cycles.

## Test plan
- Reset then idle: RESET high 2 cycles → all outputs 0. With enable=0 and 3 vs falling edges → no strobes, fcnt stays 0.
- Basic step: VRAM word k = k, enable=1, frames_per_step=0, fill_word=32'hDEAD_BEEF, one vs falling edge.
  - Required: words 0..279 = 20..299 and words 280..299 = DEADBEEF.
  - step_done pulses exactly 861 cycles after the first dma_rden.
- Divider: frames_per_step=2, 9 vs edges → exactly 3 step_done pulses, on the 3rd, 6th and 9th ticks.
- Arbitration: avl_busy high on a pseudo-random 50% of cycles during a step.
  - Required: no strobe ever coincides with avl_busy, VRAM result identical to the basic step, and step length = 861 + stalled cycles.
- Overrun: second vs edge injected 100 cycles into a step → overrun=1, that tick is ignored, and the step completes normally.
- Reset mid-step: RESET at cycle 400 of a step → IDLE next cycle, busy=0, no further strobes. The next enabled tick restarts from idx=0.

Source files
------------

// File: rtl/track_scroll_sequencer.sv
// track_scroll_sequencer
// Frame-synchronous scroller for the track region of VRAM. Every
// (frames_per_step+1) vertical-sync falling edges it copies each track
// word up by one row, then refreshes the vacated bottom row. The single
// Avalon-side VRAM port is shared with the CPU: the sequencer never strobes
// in a cycle where avl_busy is high and simply waits for a free cycle.
// Optional feature macro: SCROLL_FILL_EN. When defined, the bottom row is
// overwritten with fill_word. When undefined, the bottom row keeps its old
// contents and fill_word is ignored.
module track_scroll_sequencer #(
  parameter int BASE_ADDR = 0,
  parameter int ROW_WORDS = 20,
  parameter int ROWS      = 15
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        vs,
  input  logic        enable,
  input  logic [3:0]  frames_per_step,
  input  logic [31:0] fill_word,
  input  logic        avl_busy,
  output logic [8:0]  dma_addr,
  output logic        dma_rden,
  output logic        dma_wren,
  output logic [31:0] dma_wdata,
  input  logic [31:0] dma_rdata,
  output logic        busy,
  output logic        step_done,
  output logic        overrun
);

  localparam int COPY_WORDS = (ROWS - 1) * ROW_WORDS;

  // The region has to fit in the 512-word VRAM so that 9-bit address
  // arithmetic can never wrap.
  if (BASE_ADDR + ROWS * ROW_WORDS > 512) begin : g_region_too_big
    $error("track_scroll_sequencer: BASE_ADDR + ROWS*ROW_WORDS exceeds 512");
  end

  localparam logic [8:0] BASE9     = 9'(BASE_ADDR);
  localparam logic [8:0] ROW9      = 9'(ROW_WORDS);
  localparam logic [8:0] LAST_COPY = (COPY_WORDS > 0) ? 9'(COPY_WORDS - 1) : 9'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPT,
    S_WRITE,
`ifdef SCROLL_FILL_EN
    S_FILL,
`endif
    S_DONE
  } state_t;

`ifdef SCROLL_FILL_EN
  localparam logic [8:0] LAST_FILL  = 9'(ROW_WORDS - 1);
  localparam logic [8:0] FILL_BASE  = 9'(BASE_ADDR + COPY_WORDS);
  localparam state_t     AFTER_COPY = S_FILL;
`else
  localparam state_t     AFTER_COPY = S_DONE;
  logic unused_fill_word;
  assign unused_fill_word = ^fill_word;
`endif

  state_t      state_q, state_d;
  logic [8:0]  idx_q, idx_d;
  logic [31:0] hold_q;
  logic [3:0]  fcnt_q;
  logic        vs_q;
  logic        tick;
  logic        idle;
  logic        start_step;
  logic [8:0]  src_addr;
  logic [8:0]  dst_addr;

  assign tick       = vs_q & ~vs;
  assign idle       = (state_q == S_IDLE);
  assign start_step = tick & idle & enable & (fcnt_q == frames_per_step);
  assign src_addr   = BASE9 + idx_q + ROW9;
  assign dst_addr   = BASE9 + idx_q;
  assign busy       = ~idle;

  // State and word-index registers; a reset abandons any step in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Frame divider, sync edge detector, read-data holding register and the
  // sticky overrun flag. Ticks that land mid-step are dropped without
  // touching the divider.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      vs_q    <= 1'b1;
      fcnt_q  <= '0;
      hold_q  <= '0;
      overrun <= 1'b0;
    end else begin
      vs_q <= vs;
      if (state_q == S_CAPT) begin
        hold_q <= dma_rdata;
      end
      if (tick && !idle) begin
        overrun <= 1'b1;
      end
      if (!enable) begin
        fcnt_q <= '0;
      end else if (tick && idle) begin
        fcnt_q <= (fcnt_q == frames_per_step) ? 4'd0 : fcnt_q + 4'd1;
      end
    end
  end

  // Step sequencing and VRAM strobes; every strobe is gated by avl_busy so
  // a busy cycle simply repeats the current state.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    dma_addr  = '0;
    dma_rden  = 1'b0;
    dma_wren  = 1'b0;
    dma_wdata = '0;
    step_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_step) begin
          state_d = S_READ;
          idx_d   = '0;
        end
      end
      S_READ: begin
        if (COPY_WORDS == 0) begin
          state_d = AFTER_COPY;
          idx_d   = '0;
        end else if (!avl_busy) begin
          dma_rden = 1'b1;
          dma_addr = src_addr;
          state_d  = S_CAPT;
        end
      end
      S_CAPT: begin
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (!avl_busy) begin
          dma_wren  = 1'b1;
          dma_addr  = dst_addr;
          dma_wdata = hold_q;
          if (idx_q == LAST_COPY) begin
            idx_d   = '0;
            state_d = AFTER_COPY;
          end else begin
            idx_d   = idx_q + 9'd1;
            state_d = S_READ;
          end
        end
      end
`ifdef SCROLL_FILL_EN
      S_FILL: begin
        if (!avl_busy) begin
          dma_wren  = 1'b1;
          dma_addr  = FILL_BASE + idx_q;
          dma_wdata = fill_word;
          if (idx_q == LAST_FILL) begin
            idx_d   = '0;
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 9'd1;
          end
        end
      end
`endif
      S_DONE: begin
        step_done = 1'b1;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_track_scroll_sequencer.sv
// Self-checking bench for track_scroll_sequencer. A behavioural VRAM sits on
// the DMA port; expected VRAM images are built by shifting a plain array,
// and stalled step lengths come from walking a list of port operations
// against the random avl_busy pattern.
module tb_track_scroll_sequencer;

  localparam int BASE_ADDR  = 0;
  localparam int ROW_WORDS  = 20;
  localparam int ROWS       = 15;
  localparam int COPY_WORDS = (ROWS - 1) * ROW_WORDS;
`ifdef SCROLL_FILL_EN
  localparam int FILL_WORDS = ROW_WORDS;
`else
  localparam int FILL_WORDS = 0;
`endif
  localparam int STEP_LEN   = 3 * COPY_WORDS + FILL_WORDS + 1;
  localparam int PAT_LEN    = 4096;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        vs;
  logic        enable;
  logic [3:0]  frames_per_step;
  logic [31:0] fill_word;
  logic        avl_busy;
  logic [8:0]  dma_addr;
  logic        dma_rden;
  logic        dma_wren;
  logic [31:0] dma_wdata;
  logic [31:0] dma_rdata;
  logic        busy;
  logic        step_done;
  logic        overrun;

  logic [31:0] vram    [512];
  logic [31:0] exp_mem [512];
  bit          busy_pat [PAT_LEN];
  logic        load_req;
  logic [31:0] load_seed;
  int          n_checks  = 0;
  int          n_pass    = 0;
  int          n_strobes = 0;
  int          n_viol    = 0;
  int          diff_first;

  track_scroll_sequencer #(
    .BASE_ADDR(BASE_ADDR),
    .ROW_WORDS(ROW_WORDS),
    .ROWS     (ROWS)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .vs             (vs),
    .enable         (enable),
    .frames_per_step(frames_per_step),
    .fill_word      (fill_word),
    .avl_busy       (avl_busy),
    .dma_addr       (dma_addr),
    .dma_rden       (dma_rden),
    .dma_wren       (dma_wren),
    .dma_wdata      (dma_wdata),
    .dma_rdata      (dma_rdata),
    .busy           (busy),
    .step_done      (step_done),
    .overrun        (overrun)
  );

  always #5 CLK = ~CLK;

  // VRAM with one-cycle read latency; load_req paints word i with i^seed.
  always @(posedge CLK) begin
    if (load_req) begin
      for (int i = 0; i < 512; i++) vram[i] <= 32'(i) ^ load_seed;
    end else begin
      if (dma_wren) vram[dma_addr] <= dma_wdata;
      if (dma_rden) dma_rdata <= vram[dma_addr];
    end
  end

  // Port-rule monitor: counts strobes and any strobe overlap or strobe
  // issued while the Avalon side owns the port.
  always @(negedge CLK) begin
    if (dma_rden || dma_wren) n_strobes++;
    if (dma_rden && dma_wren) n_viol++;
    if ((dma_rden || dma_wren) && avl_busy) n_viol++;
  end

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_vram(input logic [31:0] seed);
    load_seed = seed;
    load_req  = 1'b1;
    next_cycle();
    load_req  = 1'b0;
    for (int i = 0; i < 512; i++) exp_mem[i] = 32'(i) ^ seed;
  endtask

  // Expected effect of one complete step on exp_mem.
  task automatic apply_step_model(input logic [31:0] fw);
    for (int i = 0; i < COPY_WORDS; i++)
      exp_mem[BASE_ADDR + i] = exp_mem[BASE_ADDR + i + ROW_WORDS];
    for (int i = 0; i < FILL_WORDS; i++)
      exp_mem[BASE_ADDR + COPY_WORDS + i] = fw;
  endtask

  function automatic int vram_diffs();
    int n = 0;
    diff_first = 0;
    for (int i = 0; i < 512; i++) begin
      if (vram[i] !== exp_mem[i]) begin
        if (n == 0) diff_first = i;
        n++;
      end
    end
    return n;
  endfunction

  // Cycle (relative to the first READ cycle) at which DONE should appear:
  // each read/write/fill needs a cycle with avl_busy low, the capture after
  // a read always takes exactly one cycle.
  function automatic int model_done_cycle();
    int c = 0;
    for (int w = 0; w < COPY_WORDS; w++) begin
      while (c < PAT_LEN - 1 && busy_pat[c]) c++;
      c += 2;
      while (c < PAT_LEN - 1 && busy_pat[c]) c++;
      c += 1;
    end
    for (int w = 0; w < FILL_WORDS; w++) begin
      while (c < PAT_LEN - 1 && busy_pat[c]) c++;
      c += 1;
    end
    return c;
  endfunction

  // One sync falling edge; reports whether a step started from it.
  task automatic frame_edge(output bit started);
    vs = 1'b0;
    next_cycle();
    vs = 1'b1;
    @(negedge CLK);
    started = busy;
    next_cycle();
  endtask

  task automatic wait_done(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < max_cycles && !ok; c++) begin
      @(negedge CLK);
      if (step_done) ok = 1'b1;
      next_cycle();
    end
  endtask

  // Fires a sync edge and follows the step cycle by cycle. Cycle 0 is the
  // cycle after the tick. Optional second edge at inject_at.
  task automatic run_step(input bit use_pat, input int inject_at, input int max_cycles,
                          output int first_rd, output int done_at, output logic [8:0] first_addr);
    first_rd   = -1;
    done_at    = -1;
    first_addr = '0;
    vs = 1'b0;
    next_cycle();
    for (int c = 0; c < max_cycles && done_at < 0; c++) begin
      vs       = (c == inject_at) ? 1'b0 : 1'b1;
      avl_busy = use_pat ? busy_pat[c] : 1'b0;
      @(negedge CLK);
      if (dma_rden && first_rd < 0) begin
        first_rd   = c;
        first_addr = dma_addr;
      end
      if (step_done) done_at = c;
      next_cycle();
    end
    vs       = 1'b1;
    avl_busy = 1'b0;
  endtask

  task automatic test_reset();
    bit started;
    bit seen_busy = 1'b0;
    bit ok;
    int s0;
    RESET = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge CLK);
    n_checks++; if (dma_rden !== 1'b0) $display("[TB] FAIL reset_rden: got %b want 0", dma_rden); else n_pass++;
    n_checks++; if (dma_wren !== 1'b0) $display("[TB] FAIL reset_wren: got %b want 0", dma_wren); else n_pass++;
    n_checks++; if (dma_addr !== 9'd0) $display("[TB] FAIL reset_addr: got %h want 0", dma_addr); else n_pass++;
    n_checks++; if (dma_wdata !== 32'd0) $display("[TB] FAIL reset_wdata: got %h want 0", dma_wdata); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (step_done !== 1'b0) $display("[TB] FAIL reset_step_done: got %b want 0", step_done); else n_pass++;
    n_checks++; if (overrun !== 1'b0) $display("[TB] FAIL reset_overrun: got %b want 0", overrun); else n_pass++;
    next_cycle();
    RESET = 1'b0;
    load_vram(32'd0);
    enable = 1'b0;
    frames_per_step = 4'd0;
    s0 = n_strobes;
    repeat (3) begin
      frame_edge(started);
      if (started) seen_busy = 1'b1;
      repeat (5) next_cycle();
    end
    n_checks++; if (seen_busy !== 1'b0) $display("[TB] FAIL disabled_no_step: got %b want 0", seen_busy); else n_pass++;
    n_checks++; if (n_strobes - s0 !== 0) $display("[TB] FAIL disabled_strobes: got %0d want 0", n_strobes - s0); else n_pass++;
    enable = 1'b1;
    frame_edge(started);
    n_checks++; if (started !== 1'b1) $display("[TB] FAIL fcnt_held_zero: started %b want 1", started); else n_pass++;
    wait_done(STEP_LEN + 10, ok);
    n_checks++; if (ok !== 1'b1) $display("[TB] FAIL first_step_done: got %b want 1", ok); else n_pass++;
  endtask

  task automatic test_basic_step();
    int first_rd, done_at, s0, v0, nd;
    logic [8:0] first_addr;
    load_vram(32'd0);
    enable = 1'b1;
    frames_per_step = 4'd0;
    fill_word = 32'hDEAD_BEEF;
    s0 = n_strobes;
    v0 = n_viol;
    run_step(1'b0, -1, PAT_LEN, first_rd, done_at, first_addr);
    apply_step_model(32'hDEAD_BEEF);
    n_checks++; if (first_rd !== 0) $display("[TB] FAIL basic_first_read: cycle %0d want 0", first_rd); else n_pass++;
    n_checks++; if (first_addr !== 9'(BASE_ADDR + ROW_WORDS)) $display("[TB] FAIL basic_first_addr: got %0d want %0d", first_addr, BASE_ADDR + ROW_WORDS); else n_pass++;
    n_checks++; if (done_at - first_rd + 1 !== STEP_LEN) $display("[TB] FAIL basic_length: got %0d want %0d", done_at - first_rd + 1, STEP_LEN); else n_pass++;
    n_checks++; if (n_strobes - s0 !== 2 * COPY_WORDS + FILL_WORDS) $display("[TB] FAIL basic_strobes: got %0d want %0d", n_strobes - s0, 2 * COPY_WORDS + FILL_WORDS); else n_pass++;
    n_checks++; if (n_viol - v0 !== 0) $display("[TB] FAIL basic_port_rules: got %0d want 0", n_viol - v0); else n_pass++;
    nd = vram_diffs();
    n_checks++; if (nd !== 0) $display("[TB] FAIL basic_vram: %0d words differ, first %0d got %h want %h", nd, diff_first, vram[diff_first], exp_mem[diff_first]); else n_pass++;
    @(negedge CLK);
    n_checks++; if ({busy, step_done} !== 2'b00) $display("[TB] FAIL basic_after_done: busy/step_done %b want 00", {busy, step_done}); else n_pass++;
    next_cycle();
  endtask

  task automatic test_divider();
    bit started, ok;
    int n_done = 0;
    enable = 1'b0;
    next_cycle();
    enable = 1'b1;
    frames_per_step = 4'd2;
    for (int e = 1; e <= 9; e++) begin
      frame_edge(started);
      n_checks++; if (started !== (e % 3 == 0)) $display("[TB] FAIL divider_edge%0d: started %b want %b", e, started, (e % 3 == 0)); else n_pass++;
      if (started) begin
        wait_done(STEP_LEN + 10, ok);
        if (ok) n_done++;
      end
      repeat (3) next_cycle();
    end
    n_checks++; if (n_done !== 3) $display("[TB] FAIL divider_done_count: got %0d want 3", n_done); else n_pass++;
  endtask

  task automatic test_arbitration();
    int first_rd, done_at, v0, exp_done, exp_first, nd;
    logic [8:0] first_addr;
    logic [31:0] seed, fw;
    frames_per_step = 4'd0;
    enable = 1'b1;
    for (int it = 0; it < 2; it++) begin
      seed = (it == 0) ? 32'd0 : $urandom;
      fw   = (it == 0) ? 32'hDEAD_BEEF : $urandom;
      fill_word = fw;
      load_vram(seed);
      for (int c = 0; c < PAT_LEN; c++) busy_pat[c] = ($urandom_range(0, 1) == 1);
      exp_done  = model_done_cycle();
      exp_first = 0;
      while (busy_pat[exp_first]) exp_first++;
      v0 = n_viol;
      run_step(1'b1, -1, PAT_LEN, first_rd, done_at, first_addr);
      apply_step_model(fw);
      $display("[TB] arbitration pass %0d: %0d stalled cycles expected", it, exp_done + 1 - STEP_LEN);
      n_checks++; if (n_viol - v0 !== 0) $display("[TB] FAIL arb_port_rules%0d: got %0d want 0", it, n_viol - v0); else n_pass++;
      n_checks++; if (first_rd !== exp_first) $display("[TB] FAIL arb_first_read%0d: got %0d want %0d", it, first_rd, exp_first); else n_pass++;
      n_checks++; if (done_at !== exp_done) $display("[TB] FAIL arb_length%0d: done at %0d want %0d", it, done_at, exp_done); else n_pass++;
      nd = vram_diffs();
      n_checks++; if (nd !== 0) $display("[TB] FAIL arb_vram%0d: %0d words differ, first %0d got %h want %h", it, nd, diff_first, vram[diff_first], exp_mem[diff_first]); else n_pass++;
    end
  endtask

  task automatic test_overrun();
    int first_rd, done_at, nd;
    logic [8:0] first_addr;
    logic [31:0] fw;
    bit started, ok;
    bit seen_busy = 1'b0;
    fw = $urandom;
    fill_word = fw;
    frames_per_step = 4'd0;
    enable = 1'b1;
    load_vram($urandom);
    n_checks++; if (overrun !== 1'b0) $display("[TB] FAIL overrun_before: got %b want 0", overrun); else n_pass++;
    run_step(1'b0, 100, PAT_LEN, first_rd, done_at, first_addr);
    apply_step_model(fw);
    n_checks++; if (overrun !== 1'b1) $display("[TB] FAIL overrun_set: got %b want 1", overrun); else n_pass++;
    n_checks++; if (done_at !== STEP_LEN - 1) $display("[TB] FAIL overrun_length: done at %0d want %0d", done_at, STEP_LEN - 1); else n_pass++;
    nd = vram_diffs();
    n_checks++; if (nd !== 0) $display("[TB] FAIL overrun_vram: %0d words differ, first %0d got %h want %h", nd, diff_first, vram[diff_first], exp_mem[diff_first]); else n_pass++;
    repeat (10) begin
      @(negedge CLK);
      if (busy) seen_busy = 1'b1;
      next_cycle();
    end
    n_checks++; if (seen_busy !== 1'b0) $display("[TB] FAIL overrun_tick_dropped: busy seen %b want 0", seen_busy); else n_pass++;
    frame_edge(started);
    n_checks++; if (started !== 1'b1) $display("[TB] FAIL overrun_fcnt_kept: started %b want 1", started); else n_pass++;
    wait_done(STEP_LEN + 10, ok);
    n_checks++; if ({ok, overrun} !== 2'b11) $display("[TB] FAIL overrun_sticky: done/overrun %b want 11", {ok, overrun}); else n_pass++;
  endtask

  task automatic test_reset_mid_step();
    int first_rd, done_at, s0, nd;
    logic [8:0] first_addr;
    logic [31:0] fw;
    // Unstalled, word w is written in cycle 3w+2, so 133 words land before cycle 400.
    localparam int WORDS_BEFORE_RESET = (400 - 2) / 3 + 1;
    fw = $urandom;
    fill_word = fw;
    frames_per_step = 4'd0;
    enable = 1'b1;
    load_vram($urandom);
    run_step(1'b0, -1, 400, first_rd, done_at, first_addr);
    RESET = 1'b1;
    next_cycle();
    RESET = 1'b0;
    s0 = n_strobes;
    @(negedge CLK);
    n_checks++; if (busy !== 1'b0) $display("[TB] FAIL midreset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (overrun !== 1'b0) $display("[TB] FAIL midreset_overrun: got %b want 0", overrun); else n_pass++;
    repeat (50) next_cycle();
    n_checks++; if (n_strobes - s0 !== 0) $display("[TB] FAIL midreset_strobes: got %0d want 0", n_strobes - s0); else n_pass++;
    for (int i = 0; i < WORDS_BEFORE_RESET; i++)
      exp_mem[BASE_ADDR + i] = exp_mem[BASE_ADDR + i + ROW_WORDS];
    nd = vram_diffs();
    n_checks++; if (nd !== 0) $display("[TB] FAIL midreset_partial: %0d words differ, first %0d got %h want %h", nd, diff_first, vram[diff_first], exp_mem[diff_first]); else n_pass++;
    run_step(1'b0, -1, PAT_LEN, first_rd, done_at, first_addr);
    apply_step_model(fw);
    n_checks++; if (first_addr !== 9'(BASE_ADDR + ROW_WORDS)) $display("[TB] FAIL restart_first_addr: got %0d want %0d", first_addr, BASE_ADDR + ROW_WORDS); else n_pass++;
    n_checks++; if (done_at !== STEP_LEN - 1) $display("[TB] FAIL restart_length: done at %0d want %0d", done_at, STEP_LEN - 1); else n_pass++;
    nd = vram_diffs();
    n_checks++; if (nd !== 0) $display("[TB] FAIL restart_vram: %0d words differ, first %0d got %h want %h", nd, diff_first, vram[diff_first], exp_mem[diff_first]); else n_pass++;
  endtask

  initial begin
    RESET           = 1'b1;
    vs              = 1'b1;
    enable          = 1'b0;
    frames_per_step = 4'd0;
    fill_word       = 32'd0;
    avl_busy        = 1'b0;
    load_req        = 1'b0;
    load_seed       = 32'd0;
    $display("[TB] track_scroll_sequencer bench, step length %0d cycles", STEP_LEN);
    test_reset();
    test_basic_step();
    test_divider();
    test_arbitration();
    test_overrun();
    test_reset_mid_step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
